// File: rtl/bus_turn_ctrl.sv
// bus_turn_ctrl: half-duplex bus arbiter/sequencer with turnaround gaps; define BUS_CTRL_TIMEOUT_EN to enable the receive watchdog
module bus_turn_ctrl #(
  parameter int TURN_CYCLES = 2,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_last_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       peer_req_i,
  input  logic       peer_stb_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       tx_oe,
  output logic       tx_stb_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       err_o
);
  typedef enum logic [2:0] {IDLE, TURN_TX, TX, TURN_RX, RX} state_t;
  state_t state, state_nx;
  logic [3:0] turn_cnt;
  logic [7:0] burst_cnt, burst_inc;
  logic hs, req, turn_done, timeout, lock;
  assign tx_ready_o = state == TX;
  assign hs = tx_valid_i && tx_ready_o;
  assign req = peer_req_i && !lock;
  assign turn_done = turn_cnt == 4'(TURN_CYCLES - 1);
  assign burst_inc = burst_cnt == 8'hff ? burst_cnt : burst_cnt + 8'd1;
  // next-state selection; the peer wins every tie with the local stream
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req ? RX : tx_valid_i ? TURN_TX : IDLE;
      TURN_TX: state_nx = req ? RX : turn_done ? TX : TURN_TX;
      TX:      state_nx = (!tx_valid_i || tx_last_i || (req && burst_inc >= 8'(MAX_BURST))) ? TURN_RX : TX;
      TURN_RX: state_nx = turn_done ? IDLE : TURN_RX;
      RX:      state_nx = (!peer_req_i || timeout) ? IDLE : RX;
      default: state_nx = IDLE;
    endcase
  end
  // state, counters and registered pad/stream outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      turn_cnt <= 4'd0;
      burst_cnt <= 8'd0;
      tx_oe <= 1'b1;
      data_o <= 8'h00;
      tx_stb_o <= 1'b0;
      rx_data_o <= 8'h00;
      rx_valid_o <= 1'b0;
    end else begin
      state <= state_nx;
      turn_cnt <= (state_nx == state && (state == TURN_TX || state == TURN_RX)) ? turn_cnt + 4'd1 : 4'd0;
      burst_cnt <= (state == IDLE && state_nx == TURN_TX) ? 8'd0 : hs ? burst_inc : burst_cnt;
      tx_oe <= !hs;
      tx_stb_o <= hs;
      if (hs) data_o <= tx_data_i;
      rx_valid_o <= state == RX && peer_stb_i;
      if (state == RX && peer_stb_i) rx_data_o <= data_i;
    end
  end
`ifdef BUS_CTRL_TIMEOUT_EN
  logic [6:0] idle_cnt;
  logic err;
  assign timeout = state == RX && peer_req_i && !peer_stb_i && idle_cnt == 7'(TIMEOUT - 1);
  assign err_o = err;
  // receive watchdog; lock keeps RX closed until the peer drops its request once
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_cnt <= 7'd0;
      err <= 1'b0;
      lock <= 1'b0;
    end else begin
      idle_cnt <= (state != RX || peer_stb_i) ? 7'd0 : idle_cnt + 7'd1;
      err <= err || timeout;
      lock <= timeout || (lock && peer_req_i);
    end
  end
`else
  assign timeout = TIMEOUT < 0;
  assign lock = 1'b0;
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_bus_turn_ctrl.sv
// tb_bus_turn_ctrl: randomized and directed checks of bus_turn_ctrl against a cycle model
module tb_bus_turn_ctrl;
  localparam int TURN = 2;
  localparam int MAXB = 4;
  localparam int TMO = 8;
  localparam int M_IDLE = 0;
  localparam int M_PRE = 1;
  localparam int M_SEND = 2;
  localparam int M_POST = 3;
  localparam int M_PEER = 4;
  logic clk_i = 1'b0;
  logic rst_i;
  logic [7:0] tx_data_i;
  logic tx_last_i, tx_valid_i, tx_ready_o;
  logic peer_req_i, peer_stb_i;
  logic [7:0] data_i, data_o, rx_data_o;
  logic tx_oe, tx_stb_o, rx_valid_o, err_o;
  int n_chk = 0;
  int n_fail = 0;
  logic [8:0] src_q[$];
  bit src_on;
  int m_mode, m_gap, m_burst, m_quiet;
  bit m_lock, m_err;
  logic e_oe, e_stb, e_rxv, e_ready;
  logic [7:0] e_data, e_rxd;
  logic [20:0] obs, expv;

  bus_turn_ctrl #(.TURN_CYCLES(TURN), .MAX_BURST(MAXB), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tx_data_i(tx_data_i), .tx_last_i(tx_last_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .peer_req_i(peer_req_i),
    .peer_stb_i(peer_stb_i), .data_i(data_i), .data_o(data_o), .tx_oe(tx_oe),
    .tx_stb_o(tx_stb_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  assign e_ready = m_mode == M_SEND;
  assign obs = {tx_oe, tx_stb_o, data_o, tx_ready_o, rx_valid_o, rx_data_o, err_o};
  assign expv = {e_oe, e_stb, e_data, e_ready, e_rxv, e_rxd, m_err};

  always @(posedge clk_i) begin : model
    bit ok, take;
    if (rst_i) begin
      m_mode = M_IDLE; m_gap = 0; m_burst = 0; m_quiet = 0; m_lock = 0; m_err = 0;
      e_oe = 1; e_stb = 0; e_data = 8'h00; e_rxv = 0; e_rxd = 8'h00;
    end else begin
      take = tx_valid_i && m_mode == M_SEND;
      e_oe = !take;
      e_stb = take;
      if (take) e_data = tx_data_i;
      e_rxv = m_mode == M_PEER && peer_stb_i;
      if (e_rxv) e_rxd = data_i;
      ok = peer_req_i && !m_lock;
      m_lock = m_lock && peer_req_i;
      case (m_mode)
        M_IDLE: if (ok) begin m_mode = M_PEER; m_quiet = 0; end
                else if (tx_valid_i) begin m_mode = M_PRE; m_gap = TURN; m_burst = 0; end
        M_PRE: if (ok) begin m_mode = M_PEER; m_quiet = 0; end
               else begin m_gap--; if (m_gap == 0) m_mode = M_SEND; end
        M_SEND: if (!take) begin m_mode = M_POST; m_gap = TURN; end
                else begin
                  if (m_burst < 255) m_burst++;
                  if (tx_last_i || (ok && m_burst >= MAXB)) begin m_mode = M_POST; m_gap = TURN; end
                end
        M_POST: begin m_gap--; if (m_gap == 0) m_mode = M_IDLE; end
        default: if (!peer_req_i) m_mode = M_IDLE;
                 else begin
`ifdef BUS_CTRL_TIMEOUT_EN
                   m_quiet = peer_stb_i ? 0 : m_quiet + 1;
                   if (m_quiet == TMO) begin m_err = 1; m_lock = 1; m_mode = M_IDLE; end
`endif
                 end
      endcase
    end
  end

  task automatic step();
    logic [8:0] h;
    bit hs_p;
    h = 9'h000;
    if (src_q.size() > 0) h = src_q[0];
    tx_valid_i = src_on && src_q.size() > 0;
    tx_data_i = tx_valid_i ? h[7:0] : 8'h00;
    tx_last_i = tx_valid_i && h[8];
    hs_p = tx_valid_i && e_ready;
    @(posedge clk_i);
    @(negedge clk_i);
    if (hs_p) void'(src_q.pop_front());
  endtask

  task automatic do_reset();
    rst_i = 1; src_on = 0; src_q.delete();
    peer_req_i = 0; peer_stb_i = 0; data_i = 8'h00;
    step(); step();
    rst_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (tx_oe !== 1'b1) begin n_fail++; $display("FAIL reset_oe got %b expected 1", tx_oe); end
    n_chk++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h expected 00", data_o); end
    n_chk++; if (tx_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_stb got %b expected 0", tx_stb_o); end
    n_chk++; if (rx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_rxdata got %h expected 00", rx_data_o); end
    n_chk++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rxvalid got %b expected 0", rx_valid_o); end
    n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b expected 0", err_o); end
    n_chk++; if (tx_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b expected 0", tx_ready_o); end
    for (int i = 0; i < 4; i++) src_q.push_back({i == 3, 8'h31 + 8'(i)});
    src_on = 1;
    for (int i = 0; i < 10 && tx_stb_o !== 1'b1; i++) begin
      step();
      n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL model_midburst got %h expected %h", obs, expv); end
    end
    n_chk++; if (tx_stb_o !== 1'b1) begin n_fail++; $display("FAIL midburst_start got %b expected 1", tx_stb_o); end
    rst_i = 1; src_on = 0; src_q.delete();
    step();
    rst_i = 0;
    n_chk++; if (tx_oe !== 1'b1) begin n_fail++; $display("FAIL midburst_release got %b expected 1", tx_oe); end
    n_chk++; if (tx_stb_o !== 1'b0) begin n_fail++; $display("FAIL midburst_stb got %b expected 0", tx_stb_o); end
    step();
    n_chk++; if (tx_ready_o !== 1'b0 || tx_oe !== 1'b1) begin n_fail++; $display("FAIL midburst_idle got ready=%b oe=%b expected ready=0 oe=1", tx_ready_o, tx_oe); end
  endtask

  task automatic test_single_packet();
    logic [7:0] got[$];
    logic [7:0] want[3];
    int first, last, ndrv;
    want[0] = 8'hA5; want[1] = 8'h5A; want[2] = 8'hFF;
    do_reset();
    src_q.push_back(9'h0A5); src_q.push_back(9'h05A); src_q.push_back(9'h1FF);
    src_on = 1;
    first = -1; last = -1; ndrv = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL model_single c=%0d got %h expected %h", c, obs, expv); end
      if (tx_oe === 1'b0) begin if (first < 0) first = c; last = c; ndrv++; end
      if (tx_stb_o === 1'b1) got.push_back(data_o);
    end
    n_chk++; if (first !== TURN + 2) begin n_fail++; $display("FAIL single_first_drive got %0d expected %0d", first, TURN + 2); end
    n_chk++; if (ndrv !== 3 || last - first !== 2) begin n_fail++; $display("FAIL single_drive_len got %0d (span %0d) expected 3", ndrv, last - first + 1); end
    n_chk++; if (got.size() !== 3) begin n_fail++; $display("FAIL single_count got %0d expected 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_chk++; if (got[i] !== want[i]) begin n_fail++; $display("FAIL single_byte%0d got %h expected %h", i, got[i], want[i]); end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] rx[$];
    int bad_ready, bad_oe, late_rx, c3;
    do_reset();
    src_q.push_back(9'h1C3);
    src_on = 1; peer_req_i = 1;
    bad_ready = 0; bad_oe = 0;
    for (int c = 1; c <= 10; c++) begin
      peer_stb_i = c == 3 || c == 5;
      data_i = c == 3 ? 8'h01 : c == 5 ? 8'h80 : 8'hEE;
      step();
      n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL model_simul c=%0d got %h expected %h", c, obs, expv); end
      if (tx_ready_o !== 1'b0) bad_ready++;
      if (tx_oe !== 1'b1) bad_oe++;
      if (rx_valid_o === 1'b1) rx.push_back(rx_data_o);
    end
    n_chk++; if (bad_ready !== 0) begin n_fail++; $display("FAIL simul_ready got %0d ready cycles expected 0", bad_ready); end
    n_chk++; if (bad_oe !== 0) begin n_fail++; $display("FAIL simul_oe got %0d driven cycles expected 0", bad_oe); end
    n_chk++; if (rx.size() !== 2) begin n_fail++; $display("FAIL simul_rx_count got %0d expected 2", rx.size()); end
    if (rx.size() == 2) begin
      n_chk++; if (rx[0] !== 8'h01) begin n_fail++; $display("FAIL simul_rx0 got %h expected 01", rx[0]); end
      n_chk++; if (rx[1] !== 8'h80) begin n_fail++; $display("FAIL simul_rx1 got %h expected 80", rx[1]); end
    end
    peer_req_i = 0; peer_stb_i = 1; data_i = 8'h55;
    late_rx = 0; c3 = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL model_simul_rel c=%0d got %h expected %h", c, obs, expv); end
      if (rx_valid_o === 1'b1 && rx_data_o === 8'h55) late_rx++;
      if (tx_stb_o === 1'b1 && data_o === 8'hC3) c3++;
    end
    peer_stb_i = 0;
    n_chk++; if (late_rx !== 1) begin n_fail++; $display("FAIL simul_deassert_strobe got %0d captures expected 1", late_rx); end
    n_chk++; if (c3 !== 1) begin n_fail++; $display("FAIL simul_tx_after got %0d expected 1", c3); end
  endtask

  task automatic test_burst_yield();
    logic [7:0] got[$];
    int drop, first;
    do_reset();
    for (int i = 0; i < 10; i++) src_q.push_back({i == 9, 8'h10 + 8'(i)});
    src_on = 1;
    for (int c = 1; c <= 14; c++) begin
      if (src_q.size() == 9) peer_req_i = 1;
      step();
      n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL model_burst c=%0d got %h expected %h", c, obs, expv); end
      if (tx_stb_o === 1'b1) got.push_back(data_o);
    end
    n_chk++; if (got.size() !== MAXB) begin n_fail++; $display("FAIL burst_yield_count got %0d expected %0d", got.size(), MAXB); end
    peer_stb_i = 1; data_i = 8'h3C;
    step();
    peer_stb_i = 0;
    n_chk++; if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h3C) begin n_fail++; $display("FAIL burst_rx got v=%b d=%h expected v=1 d=3c", rx_valid_o, rx_data_o); end
    peer_req_i = 0;
    drop = 0; first = -1;
    for (int c = 1; c <= 25; c++) begin
      step();
      n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL model_burst2 c=%0d got %h expected %h", c, obs, expv); end
      if (tx_stb_o === 1'b1) begin got.push_back(data_o); if (first < 0) first = c; end
    end
    n_chk++; if (first - drop !== TURN + 3) begin n_fail++; $display("FAIL burst_new_turn got %0d expected %0d", first - drop, TURN + 3); end
    n_chk++; if (got.size() !== 10) begin n_fail++; $display("FAIL burst_total got %0d expected 10", got.size()); end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      n_chk++; if (got[i] !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL burst_byte%0d got %h expected %h", i, got[i], 8'h10 + 8'(i)); end
    end
  endtask

  task automatic test_starvation();
    logic [7:0] got[$];
    int first, ndrv;
    do_reset();
    src_q.push_back(9'h021); src_q.push_back(9'h022);
    src_on = 1;
    for (int c = 1; c <= 12; c++) begin
      step();
      n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL model_starve c=%0d got %h expected %h", c, obs, expv); end
      if (tx_stb_o === 1'b1) got.push_back(data_o);
    end
    n_chk++; if (got.size() !== 2) begin n_fail++; $display("FAIL starve_first_count got %0d expected 2", got.size()); end
    src_q.push_back(9'h123);
    first = -1; ndrv = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL model_starve2 c=%0d got %h expected %h", c, obs, expv); end
      if (tx_oe === 1'b0) begin ndrv++; if (first < 0) first = c; end
      if (tx_stb_o === 1'b1) got.push_back(data_o);
    end
    n_chk++; if (first !== TURN + 2) begin n_fail++; $display("FAIL starve_regap got %0d expected %0d", first, TURN + 2); end
    n_chk++; if (ndrv !== 1) begin n_fail++; $display("FAIL starve_drive_len got %0d expected 1", ndrv); end
    n_chk++; if (got.size() !== 3 || got[got.size()-1] !== 8'h23) begin n_fail++; $display("FAIL starve_bytes got n=%0d expected 3 ending 23", got.size()); end
  endtask

  task automatic test_watchdog();
    do_reset();
    peer_req_i = 1;
    for (int c = 1; c <= 12; c++) begin
      step();
      n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL model_wdog c=%0d got %h expected %h", c, obs, expv); end
    end
`ifdef BUS_CTRL_TIMEOUT_EN
    n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL wdog_err got %b expected 1", err_o); end
    peer_stb_i = 1; data_i = 8'h77;
    step();
    n_chk++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL wdog_locked got %b expected 0", rx_valid_o); end
    peer_stb_i = 0; peer_req_i = 0;
    step();
    peer_req_i = 1;
    step();
    peer_stb_i = 1; data_i = 8'h99;
    step();
    peer_stb_i = 0;
    n_chk++; if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h99) begin n_fail++; $display("FAIL wdog_reenter got v=%b d=%h expected v=1 d=99", rx_valid_o, rx_data_o); end
    n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL wdog_sticky got %b expected 1", err_o); end
`else
    n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL wdog_err got %b expected 0", err_o); end
    peer_stb_i = 1; data_i = 8'h77;
    step();
    peer_stb_i = 0;
    n_chk++; if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h77) begin n_fail++; $display("FAIL wdog_held got v=%b d=%h expected v=1 d=77", rx_valid_o, rx_data_o); end
`endif
    peer_req_i = 0;
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) == 0) peer_req_i = !peer_req_i;
      peer_stb_i = $urandom_range(0, 2) == 0;
      data_i = 8'($urandom);
      if (src_q.size() < 4 && $urandom_range(0, 2) == 0) src_q.push_back({$urandom_range(0, 4) == 0, 8'($urandom)});
      src_on = $urandom_range(0, 7) != 0;
      rst_i = $urandom_range(0, 199) == 0;
      step();
      n_chk++; if (obs !== expv) begin n_fail++; $display("FAIL model_random c=%0d got %h expected %h", c, obs, expv); end
    end
    rst_i = 0;
  endtask

  initial begin
    rst_i = 1; src_on = 0; peer_req_i = 0; peer_stb_i = 0; data_i = 8'h00;
    tx_valid_i = 0; tx_data_i = 8'h00; tx_last_i = 0;
    test_reset();
    test_single_packet();
    test_simultaneous();
    test_burst_yield();
    test_starvation();
    test_watchdog();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
